// File: rtl/shift_tx.sv
// Serial transmitter for an external shift-register chain: shifts a parallel word out MSB first
// on sclk/sdat, then strobes latch and pulses done. Every output is a dedicated flop.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | ready=1, waiting for req; sdat holds its last value
//   SHIFT_LO | sclk low, sdat carries the current bit (setup half-period)
//   SHIFT_HI | sclk high, sdat unchanged (hold half-period)
//   LATCH    | sclk low, latch strobe high for one half-period
//   DONE     | one-cycle done pulse, then back to IDLE
module shift_tx #(
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 req,
  output logic                 ready,
  output logic                 done,
  output logic                 sclk,
  output logic                 sdat,
  output logic                 latch
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT_LO = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_sclk;
  logic                 r_sdat;
  logic                 r_latch;
  logic [DATA_BITS-1:0] w_shift_nxt;

  // The bit in flight always sits at the MSB of r_shift.
  assign w_shift_nxt = r_shift << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdat  <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_shift <= data;
            r_sdat  <= data[DATA_BITS-1];
            r_bit   <= BIT_MAX;
            r_cnt   <= CNT_MAX;
            r_ready <= 1'b0;
            r_state <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_MAX;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT_HI;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (r_cnt == '0) begin
            r_cnt  <= CNT_MAX;
            r_sclk <= 1'b0;
            if (r_bit == '0) begin
              r_latch <= 1'b1;
              r_state <= S_LATCH;
            end else begin
              // sdat only moves here, a full half-period after the sclk rise.
              r_bit   <= r_bit - 1'b1;
              r_shift <= w_shift_nxt;
              r_sdat  <= w_shift_nxt[DATA_BITS-1];
              r_state <= S_SHIFT_LO;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LATCH: begin
          if (r_cnt == '0) begin
            r_latch <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_sclk  <= 1'b0;
          r_latch <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign sclk  = r_sclk;
  assign sdat  = r_sdat;
  assign latch = r_latch;

endmodule

// File: tb/tb_shift_tx.sv
// Directed bench for shift_tx: a 16-bit/CLK_DIV=2 instance driven from a vector table and
// corner-case sequences, plus a 1-bit/CLK_DIV=1 instance checked cycle by cycle.
module tb_shift_tx;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, req0 = 1'b0;
  logic [15:0] data0 = '0;
  logic        ready0, done0, sclk0, sdat0, latch0;
  logic        rst1 = 1'b1, req1 = 1'b0;
  logic [0:0]  data1 = '0;
  logic        ready1, done1, sclk1, sdat1, latch1;

  always #5 clk = ~clk;

  shift_tx #(.DATA_BITS(16), .CLK_DIV(2)) u0 (
    .clk(clk), .rst(rst0), .data(data0), .req(req0),
    .ready(ready0), .done(done0), .sclk(sclk0), .sdat(sdat0), .latch(latch0));

  shift_tx #(.DATA_BITS(1), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst1), .data(data1), .req(req1),
    .ready(ready1), .done(done1), .sclk(sclk1), .sdat(sdat1), .latch(latch1));

  int n_vec = 0;
  int n_err = 0;

  // Passive observer of u0, sampled on the falling edge.
  int          cyc = 0, rises = 0, rises_in_word = 0, bad_words = 0;
  int          latch_pulses = 0, latch_run = 0, last_latch_w = 0;
  int          done_count = 0, low_run = 0, last_low = 0;
  logic [15:0] cap = '0;
  logic [15:0] word_log [0:63];
  int          done_cyc [0:63];
  logic        p_sclk = 1'b0, p_latch = 1'b0, p_ready = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst0) begin
      rises_in_word <= 0;
      low_run       <= 0;
      latch_run     <= 0;
    end else begin
      if (sclk0 && !p_sclk) begin
        rises         <= rises + 1;
        rises_in_word <= rises_in_word + 1;
        cap           <= {cap[14:0], sdat0};
      end
      if (latch0 && !p_latch) latch_pulses <= latch_pulses + 1;
      if (latch0) latch_run <= latch_run + 1;
      else begin
        if (p_latch) last_latch_w <= latch_run;
        latch_run <= 0;
      end
      if (done0 && done_count < 64) begin
        done_count           <= done_count + 1;
        word_log[done_count] <= cap;
        done_cyc[done_count] <= cyc;
        if (rises_in_word != 16) bad_words <= bad_words + 1;
        rises_in_word <= 0;
      end
      if (!ready0) low_run <= low_run + 1;
      else begin
        if (!p_ready) last_low <= low_run;
        low_run <= 0;
      end
    end
    p_sclk  <= sclk0;
    p_latch <= latch0;
    p_ready <= ready0;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input logic lvl, input string name);
    int n = 0;
    while (ready0 !== lvl && n < 400) begin
      tick();
      n++;
    end
    chk(name, (ready0 === lvl) ? 1 : 0, 1);
  endtask

  task automatic wait_dones(input int target, input string name);
    int n = 0;
    while (done_count < target && n < 1000) begin
      tick();
      n++;
    end
    chk(name, (done_count >= target) ? 1 : 0, 1);
  endtask

  task automatic send_word(input logic [15:0] d, input logic tamper, input logic [15:0] tval,
                           input logic [15:0] exp);
    int b_rise, b_done, b_latch;
    wait_ready(1'b1, "pre_ready");
    b_rise  = rises;
    b_done  = done_count;
    b_latch = latch_pulses;
    data0 = d;
    req0  = 1'b1;
    tick();
    chk("accept_ready_low", ready0, 0);
    req0 = 1'b0;
    if (tamper) data0 = tval;
    wait_dones(b_done + 1, "done_timeout");
    tick();
    tick();
    chk("word", word_log[b_done], exp);
    chk("rise_count", rises - b_rise, 16);
    chk("latch_pulses", latch_pulses - b_latch, 1);
    chk("latch_width", last_latch_w, 2);
    chk("ready_low_cycles", last_low, 67);
    chk("single_done", done_count - b_done, 1);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        tamper;
    logic [15:0] tval;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic ready, sclk, sdat, latch, done;
  } cyc_t;

  initial begin
    vec_t vt [5];
    cyc_t ct [5];
    logic [15:0] b2b [3];
    int b_done, b_rise, b_latch;

    vt[0] = '{16'hA5C3, 1'b0, 16'h0000, 16'hA5C3};
    vt[1] = '{16'h0001, 1'b1, 16'hFFFF, 16'h0001};
    vt[2] = '{16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};
    vt[3] = '{16'h0000, 1'b1, 16'hFFFF, 16'h0000};
    vt[4] = '{16'h8001, 1'b1, 16'h7FFE, 16'h8001};

    // u1 per-cycle outputs from the cycle after acceptance until back in IDLE.
    ct[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ct[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ct[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ct[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ct[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    b2b[0] = 16'h1234;
    b2b[1] = 16'h5678;
    b2b[2] = 16'h9ABC;

    // Reset with a simultaneous request: reset must win.
    req0  = 1'b1;
    data0 = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", ready0, 1);
      chk("rst_sclk_sdat", {sclk0, sdat0}, 0);
      chk("rst_latch_done", {latch0, done0}, 0);
    end
    rst0 = 1'b0;
    req0 = 1'b0;
    rst1 = 1'b0;
    tick();
    chk("idle_after_rst", {ready0, ready1}, 2'b11);

    for (int i = 0; i < 5; i++)
      send_word(vt[i].d, vt[i].tamper, vt[i].tval, vt[i].exp);
    chk("sdat_holds_in_idle", sdat0, 1);

    // Back-to-back with req held high.
    b_done  = done_count;
    b_rise  = rises;
    b_latch = latch_pulses;
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data0 = b2b[i];
      wait_ready(1'b1, "b2b_ready_hi");
      wait_ready(1'b0, "b2b_accept");
    end
    req0 = 1'b0;
    wait_dones(b_done + 3, "b2b_done_timeout");
    tick();
    tick();
    for (int i = 0; i < 3; i++) chk("b2b_word", word_log[b_done + i], b2b[i]);
    chk("b2b_spacing0", done_cyc[b_done + 1] - done_cyc[b_done], 68);
    chk("b2b_spacing1", done_cyc[b_done + 2] - done_cyc[b_done + 1], 68);
    chk("b2b_rises", rises - b_rise, 48);
    chk("b2b_latches", latch_pulses - b_latch, 3);

    // Abort during SHIFT_HI of bit 9 (the 7th sclk rise).
    wait_ready(1'b1, "abort_pre_ready");
    b_done  = done_count;
    b_rise  = rises;
    b_latch = latch_pulses;
    data0 = 16'hFFFF;
    req0  = 1'b1;
    tick();
    req0 = 1'b0;
    for (int n = 0; n < 200 && rises - b_rise < 7; n++) tick();
    chk("abort_reach_bit9", rises - b_rise, 7);
    chk("abort_in_hi", sclk0, 1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("abort_sclk_sdat", {sclk0, sdat0}, 0);
    chk("abort_ready", ready0, 1);
    for (int n = 0; n < 80; n++) tick();
    chk("abort_no_rise", rises - b_rise, 7);
    chk("abort_no_latch", latch_pulses - b_latch, 0);
    chk("abort_no_done", done_count - b_done, 0);
    send_word(16'hC3A5, 1'b0, 16'h0000, 16'hC3A5);

    // Stray req pulses while busy must not start another word.
    wait_ready(1'b1, "stray_pre_ready");
    b_done = done_count;
    b_rise = rises;
    data0 = 16'h5A0F;
    req0  = 1'b1;
    tick();
    req0 = 1'b0;
    for (int n = 0; n < 200 && done_count == b_done; n++) begin
      if (ready0 == 1'b0 && $urandom_range(0, 4) == 0) begin
        req0  = 1'b1;
        data0 = 16'($urandom);
        tick();
        req0 = 1'b0;
      end else begin
        tick();
      end
    end
    for (int n = 0; n < 6; n++) tick();
    chk("stray_word", word_log[b_done], 16'h5A0F);
    chk("stray_done_count", done_count - b_done, 1);
    chk("stray_rises", rises - b_rise, 16);
    chk("stray_idle", ready0, 1);
    chk("rises_per_done", bad_words, 0);

    // DATA_BITS=1, CLK_DIV=1 instance, checked every cycle.
    data1 = 1'b1;
    req1  = 1'b1;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("u1_ready", ready1, ct[i].ready);
      chk("u1_sclk_sdat", {sclk1, sdat1}, {ct[i].sclk, ct[i].sdat});
      chk("u1_latch_done", {latch1, done1}, {ct[i].latch, ct[i].done});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
